// File: rtl/adc_meas_sequencer.sv
// adc_meas_sequencer: paces ADC conversions after power-up settling, averages 2^AVG_LOG2 results, decodes a voltage band.
// Latency: conv_start one cycle after an enabled period tick; avg_volt/led_n/avg_valid one cycle after the closing conv_done.
// Backpressure: none; conv_done outside WAIT is dropped, and a period tick while busy is skipped and flagged as overrun.
module adc_meas_sequencer #(
  parameter int unsigned STARTUP_CYC = 65535,
  parameter int unsigned PERIOD_CYC  = 8000,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned TIMEOUT_CYC = 2000,
  parameter logic [15:0] TH1         = 16'h6500,
  parameter logic [15:0] TH2         = 16'h7500,
  parameter logic [15:0] TH3         = 16'h8500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        err_clr,
  output logic        conv_start,
  input  logic        conv_done,
  input  logic [15:0] conv_data,
  output logic        avg_valid,
  output logic [15:0] avg_volt,
  output logic [4:0]  led_n,
  output logic        timeout_err,
  output logic        overrun_err
);

  // Counter widths: $clog2(N) bits are enough to hold the terminal value N-1.
  localparam int unsigned SU_W  = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;
  localparam int unsigned PER_W = (PERIOD_CYC > 1)  ? $clog2(PERIOD_CYC)  : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  // 2^AVG_LOG2 samples of 16 bits cannot overflow 16+AVG_LOG2 bits.
  localparam int unsigned ACC_W = 16 + AVG_LOG2;

  localparam logic [SU_W-1:0]  SU_LAST  = SU_W'(STARTUP_CYC - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] SMP_LAST = CNT_W'((2 ** AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_IDLE    = 2'd1,
    ST_START   = 2'd2,
    ST_WAIT    = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [SU_W-1:0]   startup_cnt;
  logic [PER_W-1:0]  period_cnt;
  logic [TO_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]  sample_cnt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;

  logic              startup_done;
  logic              tick;
  logic              accept;
  logic              wait_expired;
  logic              avg_last;
  logic              ovr_hit;
  logic              idle_hold;
  logic [15:0]       avg_next;
  logic [4:0]        band_led_n;

  // The period counter only runs once settling is over, so tick never fires in STARTUP.
  assign startup_done = (state == ST_STARTUP) && (startup_cnt == SU_LAST);
  assign tick         = (state != ST_STARTUP) && (period_cnt == PER_LAST);

  // conv_done counts only in WAIT; on the timeout cycle it still wins over the timeout.
  assign accept       = (state == ST_WAIT) && conv_done;
  assign wait_expired = (state == ST_WAIT) && !conv_done && (wait_cnt == TO_LAST);
  assign avg_last     = accept && (sample_cnt == SMP_LAST);

  // A tick while a conversion is outstanding is dropped, not queued.
  assign ovr_hit      = tick && ((state == ST_START) || (state == ST_WAIT));
  assign idle_hold    = (state == ST_IDLE) && !enable;

  // Sum including the closing sample; the truncating divide is just a bit slice.
  assign acc_sum      = acc + ACC_W'(conv_data);
  assign avg_next     = acc_sum[AVG_LOG2 +: 16];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_STARTUP;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and conv_start decode.
  always_comb begin
    state_nxt  = state;
    conv_start = 1'b0;
    case (state)
      ST_STARTUP: begin
        if (startup_done) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (tick && enable) begin
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        conv_start = 1'b1;
        state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        // enable is deliberately ignored here: an issued conversion always completes.
        if (conv_done || wait_expired) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_STARTUP;
      end
    endcase
  end

  // Power-up settling counter: 0..STARTUP_CYC-1, then parked at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      startup_cnt <= '0;
    end else if (state == ST_STARTUP) begin
      startup_cnt <= startup_done ? '0 : startup_cnt + 1'b1;
    end else begin
      startup_cnt <= '0;
    end
  end

  // Free-running period counter, zero on the first IDLE cycle and wrapping at PERIOD_CYC-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
    end else if ((state == ST_STARTUP) || tick) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  // Conversion watchdog: cleared on the way into WAIT, counts every WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == ST_START) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Sample accumulator: cleared when an average closes or while parked in IDLE with enable low.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      sample_cnt <= '0;
    end else if (avg_last) begin
      acc        <= '0;
      sample_cnt <= '0;
    end else if (accept) begin
      acc        <= acc_sum;
      sample_cnt <= sample_cnt + 1'b1;
    end else if (idle_hold) begin
      acc        <= '0;
      sample_cnt <= '0;
    end
  end

  // Band decode of the average being formed, so led_n lands together with avg_volt.
  always_comb begin
    band_led_n = 5'b11111;
    if (avg_next == 16'h0000) begin
      band_led_n[0] = 1'b0;
    end else if (avg_next <= TH1) begin
      band_led_n[1] = 1'b0;
    end else if (avg_next <= TH2) begin
      band_led_n[2] = 1'b0;
    end else if (avg_next <= TH3) begin
      band_led_n[3] = 1'b0;
    end else begin
      band_led_n[4] = 1'b0;
    end
  end

  // Result registers: avg_valid is a one-cycle strobe, avg_volt/led_n hold until the next average.
  always_ff @(posedge clk) begin
    if (rst) begin
      avg_valid <= 1'b0;
      avg_volt  <= '0;
      led_n     <= 5'b11111;
    end else begin
      avg_valid <= avg_last;
      if (avg_last) begin
        avg_volt <= avg_next;
        led_n    <= band_led_n;
      end
    end
  end

  // Sticky error flags; a new event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      timeout_err <= wait_expired | (timeout_err & ~err_clr);
      overrun_err <= ovr_hit | (overrun_err & ~err_clr);
    end
  end

endmodule
